// File: rtl/memory_access_pkg.sv
// Shared encodings for the memory-access stage: funct3 load/store sizes,
// write-back source select, FSM states and the alignment rule.
package memory_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // state     | meaning
  // ST_IDLE   | no access outstanding; a new access may request this cycle
  // ST_REQ    | request issued, waiting for grant
  // ST_WAIT_R | load granted, waiting for read data
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } state_e;

  // Size is carried in funct3[1:0]; the unsigned variants share the rule.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/response bus between the memory stage and memory.
interface memory_access_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/memory_access_load_extend.sv
// Picks the addressed byte/halfword out of a read word and extends it.
module load_extend
  import memory_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection by the low address bits.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Sign or zero extension by access type.
  always_comb begin
    o_value = i_rdata;
    case (i_funct3)
      F3_B:    o_value = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_value = {24'd0, w_byte};
      F3_H:    o_value = {{16{w_half[15]}}, w_half};
      F3_HU:   o_value = {16'd0, w_half};
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues data-memory accesses, stalls the pipe until the
// access completes, formats loads and registers the write-back result.
module memory_access
  import memory_access_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     alu_result_mem_i,
  input  logic [31:0]     latest_rs2_value_mem_i,
  input  logic [4:0]      rd_label_mem_i,
  input  logic            reg_write_en_mem_i,
  input  logic            is_load_instr_mem_i,
  input  logic            is_store_instr_mem_i,
  input  logic            load_store_forward_sel_mem_i,
  input  logic [1:0]      wb_sel_mem_i,
  input  logic [31:0]     pc_mem_i,
  input  logic [2:0]      funct3_mem_i,
  memory_access_if.master dmem,
  output logic [31:0]     rd_value_mem_o,
  output logic            stall_mem_o,
  output logic            misaligned_o,
  output logic            reg_write_en_wb_o,
  output logic [4:0]      rd_label_wb_o,
  output logic [31:0]     rd_value_wb_o
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_access;
  logic        w_req;
  logic        w_complete;
  logic        w_stall;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_store_src;
  logic [31:0] w_load_value;
  logic [31:0] w_wb_value;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_is_mem     = is_load_instr_mem_i | is_store_instr_mem_i;
  assign w_misaligned = w_is_mem & is_misaligned(funct3_mem_i, alu_result_mem_i[1:0]);
  assign w_access     = w_is_mem & ~w_misaligned;
  assign w_pc_plus4   = pc_mem_i + 32'd4;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, request and completion; gnt only matters while requesting,
  // rvalid only while waiting for read data.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_req = 1'b1;
          if (dmem.dmem_gnt_i) begin
            if (is_load_instr_mem_i) w_state_nxt = ST_WAIT_R;
            else                     w_complete  = 1'b1;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (dmem.dmem_gnt_i) begin
          if (is_load_instr_mem_i) begin
            w_state_nxt = ST_WAIT_R;
          end else begin
            w_state_nxt = ST_IDLE;
            w_complete  = 1'b1;
          end
        end
      end
      ST_WAIT_R: begin
        if (dmem.dmem_rvalid_i) begin
          w_state_nxt = ST_IDLE;
          w_complete  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_stall      = w_access & ~w_complete;
  assign stall_mem_o  = w_stall;
  assign misaligned_o = w_misaligned & ~rst_i;

  // Store lane enables and replicated write data; loads read the lanes of
  // their own size so the memory sees a consistent byte enable.
  assign w_store_src = load_store_forward_sel_mem_i ? rd_value_wb_o : latest_rs2_value_mem_i;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_store_src;
    case (funct3_mem_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_result_mem_i[1:0];
        w_wdata = {4{w_store_src[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {alu_result_mem_i[1], 1'b0};
        w_wdata = {2{w_store_src[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = w_store_src;
      end
    endcase
  end

  assign dmem.dmem_req_o   = w_req & ~rst_i;
  assign dmem.dmem_we_o    = is_store_instr_mem_i;
  assign dmem.dmem_addr_o  = {alu_result_mem_i[31:2], 2'b00};
  assign dmem.dmem_be_o    = w_be;
  assign dmem.dmem_wdata_o = w_wdata;

  load_extend u_load_extend (
    .i_rdata   (dmem.dmem_rdata_i),
    .i_addr_lo (alu_result_mem_i[1:0]),
    .i_funct3  (funct3_mem_i),
    .o_value   (w_load_value)
  );

  // Result for the forwarding path (loads are never forwarded from here)
  // and for the write-back register.
  always_comb begin
    rd_value_mem_o = (wb_sel_mem_i == WB_PC4) ? w_pc_plus4 : alu_result_mem_i;
    case (wb_sel_mem_i)
      WB_LOAD: w_wb_value = w_load_value;
      WB_PC4:  w_wb_value = w_pc_plus4;
      default: w_wb_value = alu_result_mem_i;
    endcase
  end

  // Write-back register: a stalled or misaligned instruction leaves a bubble
  // and keeps the previous label/value so forwarding from WB stays valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_write_en_wb_o <= 1'b0;
      rd_label_wb_o     <= 5'd0;
      rd_value_wb_o     <= 32'd0;
    end else if (w_stall || w_misaligned) begin
      reg_write_en_wb_o <= 1'b0;
    end else begin
      reg_write_en_wb_o <= reg_write_en_mem_i;
      rd_label_wb_o     <= rd_label_mem_i;
      rd_value_wb_o     <= w_wb_value;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed scenarios plus randomized instructions
// with randomized grant/read latency, checked against a timeline model.
module tb_memory_access;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] alu_result_mem_i = '0;
  logic [31:0] latest_rs2_value_mem_i = '0;
  logic [4:0]  rd_label_mem_i = '0;
  logic        reg_write_en_mem_i = 1'b0;
  logic        is_load_instr_mem_i = 1'b0;
  logic        is_store_instr_mem_i = 1'b0;
  logic        load_store_forward_sel_mem_i = 1'b0;
  logic [1:0]  wb_sel_mem_i = '0;
  logic [31:0] pc_mem_i = '0;
  logic [2:0]  funct3_mem_i = '0;
  logic [31:0] rd_value_mem_o;
  logic        stall_mem_o;
  logic        misaligned_o;
  logic        reg_write_en_wb_o;
  logic [4:0]  rd_label_wb_o;
  logic [31:0] rd_value_wb_o;

  memory_access_if bus();

  memory_access dut (
    .clk_i                        (clk_i),
    .rst_i                        (rst_i),
    .alu_result_mem_i             (alu_result_mem_i),
    .latest_rs2_value_mem_i       (latest_rs2_value_mem_i),
    .rd_label_mem_i               (rd_label_mem_i),
    .reg_write_en_mem_i           (reg_write_en_mem_i),
    .is_load_instr_mem_i          (is_load_instr_mem_i),
    .is_store_instr_mem_i         (is_store_instr_mem_i),
    .load_store_forward_sel_mem_i (load_store_forward_sel_mem_i),
    .wb_sel_mem_i                 (wb_sel_mem_i),
    .pc_mem_i                     (pc_mem_i),
    .funct3_mem_i                 (funct3_mem_i),
    .dmem                         (bus),
    .rd_value_mem_o               (rd_value_mem_o),
    .stall_mem_o                  (stall_mem_o),
    .misaligned_o                 (misaligned_o),
    .reg_write_en_wb_o            (reg_write_en_wb_o),
    .rd_label_wb_o                (rd_label_wb_o),
    .rd_value_wb_o                (rd_value_wb_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  // model expectations for the current cycle
  bit          chk_en = 1'b0;
  logic        exp_req, exp_stall, exp_mis, exp_we, exp_store, exp_fwd_valid;
  logic [31:0] exp_addr, exp_wdata, exp_fwdval;
  logic [3:0]  exp_be;
  logic        exp_wb_en = 1'b0;
  logic [4:0]  exp_wb_label = '0;
  logic [31:0] exp_wb_value = '0;

  // captures from cycle 0 of the last instruction, for literal checks
  logic        cap_req, cap_stall, cap_mis, cap_we;
  logic [31:0] cap_addr, cap_wdata, cap_fwd;
  logic [3:0]  cap_be;
  int          cap_stall_cycles;

  bit          noise_hi = 1'b0;
  bit          force_rd_en = 1'b0;
  logic [31:0] force_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic misaligned_model(input logic [2:0] f3, input logic [1:0] lo);
    int size;
    size = (f3 == 3'b001 || f3 == 3'b101) ? 2 : (f3 == 3'b010 ? 4 : 1);
    return (int'(lo) % size) != 0;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] d);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (d >> (8 * int'(lo))) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (d >> (16 * int'(lo[1]))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b000:  return 4'(1 << int'(lo));
      3'b001:  return 4'(3 << (int'(lo) & 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return (d & 32'hFF) * 32'h0101_0101;
      3'b001:  return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic noise();
    return noise_hi ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // compare process
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("req", 32'(bus.dmem_req_o), 32'(exp_req));
      chk("stall", 32'(stall_mem_o), 32'(exp_stall));
      chk("misaligned", 32'(misaligned_o), 32'(exp_mis));
      chk("addr", bus.dmem_addr_o, exp_addr);
      chk("we", 32'(bus.dmem_we_o), 32'(exp_we));
      if (exp_store) begin
        chk("be", 32'(bus.dmem_be_o), 32'(exp_be));
        chk("wdata", bus.dmem_wdata_o, exp_wdata);
      end
      if (exp_fwd_valid) chk("rd_value_mem", rd_value_mem_o, exp_fwdval);
      chk("wb_en", 32'(reg_write_en_wb_o), 32'(exp_wb_en));
      chk("wb_label", 32'(rd_label_wb_o), 32'(exp_wb_label));
      chk("wb_value", rd_value_wb_o, exp_wb_value);
    end
  end

  // Presents one instruction from posedge+1 and plays the memory side with
  // grant after g cycles and, for loads, read data r cycles after the grant.
  task automatic run_instr(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] rs2,
                           input logic [31:0] pc, input logic [4:0] rd, input bit wen,
                           input logic [1:0] wsel, input bit fwd, input int g, input int r);
    bit          acc, mis;
    int          n;
    logic [31:0] ldval, sdata;
    mis = (ld || st) && misaligned_model(f3, alu[1:0]);
    acc = (ld || st) && !mis;
    n   = !acc ? 1 : (st ? g + 1 : g + r + 1);
    is_load_instr_mem_i          = ld;
    is_store_instr_mem_i         = st;
    funct3_mem_i                 = f3;
    alu_result_mem_i             = alu;
    latest_rs2_value_mem_i       = rs2;
    pc_mem_i                     = pc;
    rd_label_mem_i               = rd;
    reg_write_en_mem_i           = wen;
    wb_sel_mem_i                 = wsel;
    load_store_forward_sel_mem_i = fwd;
    sdata         = fwd ? exp_wb_value : rs2;
    exp_mis       = mis;
    exp_addr      = {alu[31:2], 2'b00};
    exp_we        = st;
    exp_store     = st && acc;
    exp_be        = be_model(f3, alu[1:0]);
    exp_wdata     = wdata_model(f3, sdata);
    exp_fwd_valid = (wsel != 2'b01);
    exp_fwdval    = (wsel == 2'b10) ? pc + 32'd4 : alu;
    ldval         = '0;
    cap_stall_cycles = 0;
    for (int c = 0; c < n; c++) begin
      bus.dmem_rdata_i = $urandom;
      if (acc && (st || c <= g)) begin
        bus.dmem_gnt_i    = (c == g);
        bus.dmem_rvalid_i = noise();
        exp_req           = 1'b1;
      end else if (acc) begin
        bus.dmem_gnt_i    = noise();
        bus.dmem_rvalid_i = (c == g + r);
        exp_req           = 1'b0;
        if (c == g + r) begin
          if (force_rd_en) bus.dmem_rdata_i = force_rd;
          ldval = fmt_load(f3, alu[1:0], bus.dmem_rdata_i);
        end
      end else begin
        bus.dmem_gnt_i    = noise();
        bus.dmem_rvalid_i = noise();
        exp_req           = 1'b0;
      end
      exp_stall = acc && (st ? (c < g) : (c < g + r));
      chk_en = 1'b1;
      #2;
      if (c == 0) begin
        cap_req   = bus.dmem_req_o;
        cap_stall = stall_mem_o;
        cap_mis   = misaligned_o;
        cap_we    = bus.dmem_we_o;
        cap_addr  = bus.dmem_addr_o;
        cap_wdata = bus.dmem_wdata_o;
        cap_be    = bus.dmem_be_o;
        cap_fwd   = rd_value_mem_o;
      end
      if (stall_mem_o) cap_stall_cycles++;
      @(posedge clk_i);
      #1;
      if (c < n - 1) exp_wb_en = 1'b0;
    end
    if (acc || !(ld || st)) begin
      exp_wb_en    = wen;
      exp_wb_label = rd;
      exp_wb_value = (wsel == 2'b01) ? ldval : ((wsel == 2'b10) ? pc + 32'd4 : alu);
    end else begin
      exp_wb_en = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [31:0] alu;
    logic [2:0]  f3;
    logic [2:0]  ld_f3 [5];
    int          kind;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bus.dmem_gnt_i    = 1'b0;
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i  = '0;

    // reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_wb_en", 32'(reg_write_en_wb_o), 32'd0);
    chk("rst_wb_label", 32'(rd_label_wb_o), 32'd0);
    chk("rst_wb_value", rd_value_wb_o, 32'd0);
    chk("rst_mis", 32'(misaligned_o), 32'd0);
    rst_i = 1'b0;

    // ALU result to rd=5
    run_instr(0, 0, 3'b000, 32'h0000_1234, 32'h0, 32'h100, 5'd5, 1, 2'b00, 0, 0, 1);
    chk("alu_wb_value", rd_value_wb_o, 32'h0000_1234);
    chk("alu_wb_label", 32'(rd_label_wb_o), 32'd5);
    chk("alu_wb_en", 32'(reg_write_en_wb_o), 32'd1);
    chk("alu_req", 32'(cap_req), 32'd0);
    chk("alu_fwd", cap_fwd, 32'h0000_1234);

    // LB at 0x103, grant after 2 cycles, read data 3 cycles after grant
    force_rd_en = 1'b1;
    force_rd    = 32'h80FF_FF00;
    run_instr(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h104, 5'd9, 1, 2'b01, 0, 2, 3);
    force_rd_en = 1'b0;
    chk("lb_wb_value", rd_value_wb_o, 32'hFFFF_FF80);
    chk("lb_wb_label", 32'(rd_label_wb_o), 32'd9);
    chk("lb_stall_cycles", 32'(cap_stall_cycles), 32'd5);

    // SH at 0x202, immediate grant
    run_instr(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h108, 5'd0, 0, 2'b00, 0, 0, 1);
    chk("sh_be", 32'(cap_be), 32'b1100);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_addr", cap_addr, 32'h0000_0200);
    chk("sh_we", 32'(cap_we), 32'd1);
    chk("sh_stall", 32'(cap_stall), 32'd0);

    // LW at 0x301 is misaligned
    run_instr(1, 0, 3'b010, 32'h0000_0301, 32'h0, 32'h10C, 5'd6, 1, 2'b01, 0, 0, 1);
    chk("lw_mis", 32'(cap_mis), 32'd1);
    chk("lw_mis_req", 32'(cap_req), 32'd0);
    chk("lw_mis_wb_en", 32'(reg_write_en_wb_o), 32'd0);

    // SW with store data forwarded from WB
    run_instr(0, 0, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h110, 5'd7, 1, 2'b00, 0, 0, 1);
    run_instr(0, 1, 3'b010, 32'h0000_0500, 32'h1111_1111, 32'h114, 5'd0, 0, 2'b00, 1, 1, 1);
    chk("sw_fwd_wdata", cap_wdata, 32'hDEAD_BEEF);

    // randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      alu  = $urandom;
      if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
      case (kind)
        0: run_instr(0, 0, 3'b000, alu, $urandom, $urandom, 5'($urandom), 1'($urandom),
                     2'b00, 0, 0, 1);
        1: run_instr(0, 0, 3'b000, alu, $urandom, $urandom, 5'($urandom), 1'($urandom),
                     2'b10, 0, 0, 1);
        2: begin
          f3 = ld_f3[$urandom_range(0, 4)];
          run_instr(1, 0, f3, alu, $urandom, $urandom, 5'($urandom), 1, 2'b01, 0,
                    $urandom_range(0, 3), $urandom_range(1, 3));
        end
        default: begin
          f3 = 3'($urandom_range(0, 2));
          run_instr(0, 1, f3, alu, $urandom, $urandom, 5'($urandom), 0, 2'b00,
                    1'($urandom), $urandom_range(0, 3), 1);
        end
      endcase
    end

    // reset pulsed while waiting for read data
    run_instr(0, 0, 3'b000, 32'hCAFE_0001, 32'h0, 32'h200, 5'd31, 1, 2'b00, 0, 0, 1);
    chk_en = 1'b0;
    is_load_instr_mem_i  = 1'b1;
    is_store_instr_mem_i = 1'b0;
    funct3_mem_i         = 3'b010;
    alu_result_mem_i     = 32'h0000_0400;
    wb_sel_mem_i         = 2'b01;
    reg_write_en_mem_i   = 1'b1;
    rd_label_mem_i       = 5'd3;
    bus.dmem_gnt_i       = 1'b1;
    bus.dmem_rvalid_i    = 1'b0;
    @(posedge clk_i);
    #1;
    bus.dmem_gnt_i = 1'b0;
    #1;
    chk("waitr_stall", 32'(stall_mem_o), 32'd1);
    chk("waitr_req", 32'(bus.dmem_req_o), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus.dmem_req_o), 32'd0);
    chk("mid_rst_mis", 32'(misaligned_o), 32'd0);
    chk("mid_rst_wb_en", 32'(reg_write_en_wb_o), 32'd0);
    chk("mid_rst_wb_label", 32'(rd_label_wb_o), 32'd0);
    chk("mid_rst_wb_value", rd_value_wb_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    is_load_instr_mem_i = 1'b0;
    reg_write_en_mem_i  = 1'b0;
    rd_label_mem_i      = 5'd0;
    alu_result_mem_i    = 32'd0;
    wb_sel_mem_i        = 2'b00;
    bus.dmem_rvalid_i   = 1'b1;
    bus.dmem_rdata_i    = $urandom;
    #1;
    chk("late_rvalid_stall", 32'(stall_mem_o), 32'd0);
    chk("late_rvalid_req", 32'(bus.dmem_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    chk("late_rvalid_wb_en", 32'(reg_write_en_wb_o), 32'd0);
    chk("late_rvalid_wb_label", 32'(rd_label_wb_o), 32'd0);
    chk("late_rvalid_wb_value", rd_value_wb_o, 32'd0);
    bus.dmem_rvalid_i = 1'b0;
    exp_wb_en    = 1'b0;
    exp_wb_label = '0;
    exp_wb_value = '0;
    // rvalid is present from the first cycle; only an idle FSM ignores it
    noise_hi = 1'b1;
    run_instr(1, 0, 3'b010, 32'h0000_0600, 32'h0, 32'h300, 5'd4, 1, 2'b01, 0, 1, 2);
    noise_hi = 1'b0;
    chk("post_rst_req", 32'(cap_req), 32'd1);
    chk("post_rst_stall", 32'(cap_stall), 32'd1);
    chk("post_rst_wb_en", 32'(reg_write_en_wb_o), 32'd1);
    chk("post_rst_wb_label", 32'(rd_label_wb_o), 32'd4);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
